int_mul_pipe: RTL and testbench

Lane-parallel, multi-cycle integer multiply pipe; the parametrised successor to the single-cycle integer execution pipe. It sits beside the integer pipe between operand fetch and writeback. It takes vector or scalar-broadcast operands and a lane mask, and returns low-half or high-half products (signed, unsigned or mixed) after a fixed, parameter-set latency. It supports stall and flush.

---
 rtl/int_mul_pipe.sv | 184 ++++++++++++++++++
 tb/tb_int_mul_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_mul_pipe.sv
// int_mul_pipe
//   Lane-parallel, fixed-latency integer multiply pipe. Each lane forms the
//   product of op0 and op1 (op1 optionally broadcast from lane 0). It returns
//   either the low half (MUL_LO) or the high half with signed/unsigned/mixed
//   operand interpretation. Latency is exactly STAGES enabled clock edges.
//   The pipe holds completely when enable is low. flush kills everything in
//   flight, and also the operation presented in the same cycle.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   enable            1 = advance every stage, 0 = every stage holds
//   flush             clear all stage valid bits at the next edge (beats enable)
//   in_valid/in_op    operation strobe and select
//                     (0 MUL_LO, 1 MULH_SS, 2 MULH_UU, 3 MULH_SU)
//   in_op0/in_op1     lane-packed operands, lane i at [i*WIDTH +: WIDTH]
//   in_op1_scalar     broadcast in_op1 lane 0 to every lane
//   in_mask           lane enables; disabled lanes return 0
//   in_tag            opaque tag carried alongside the operation
//   out_*             completing operation: valid, op, per-lane result, mask, tag
//   busy              any stage (output stage included) holds a valid operation
module int_mul_pipe #(
   parameter int TILE_ID = 0,
   parameter int LANES   = 16,
   parameter int WIDTH   = 32,
   parameter int STAGES  = 3,
   parameter int TAG_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [1:0]               in_op,
   input  logic [LANES*WIDTH-1:0]   in_op0,
   input  logic [LANES*WIDTH-1:0]   in_op1,
   input  logic                     in_op1_scalar,
   input  logic [LANES-1:0]         in_mask,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   output logic [1:0]               out_op,
   output logic [LANES*WIDTH-1:0]   out_result,
   output logic [LANES-1:0]         out_mask,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     busy
);

   localparam int LW = LANES * WIDTH;
   localparam int EW = WIDTH + 1;

   localparam logic [1:0] OP_MUL_LO  = 2'd0;
   localparam logic [1:0] OP_MULH_SS = 2'd1;
   localparam logic [1:0] OP_MULH_SU = 2'd3;

   // Control/tag pipeline; index s is stage s+1.
   logic [STAGES-1:0] valid_q;
   logic [1:0]        op_q   [STAGES];
   logic [TAG_W-1:0]  tag_q  [STAGES];
   logic [LANES-1:0]  mask_q [STAGES];

   // Stage 1 operand registers: (WIDTH+1)-bit extended operands per lane.
   logic [LANES*EW-1:0] a_ext;
   logic [LANES*EW-1:0] b_ext;
   logic [LANES*EW-1:0] a_q;
   logic [LANES*EW-1:0] b_q;

   // Per-lane result computed from the stage 1 operand registers.
   logic [LW-1:0] res_first;

   logic a_signed;
   logic b_signed;

   assign a_signed = (in_op == OP_MULH_SS) || (in_op == OP_MULH_SU);
   assign b_signed = (in_op == OP_MULH_SS);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [WIDTH-1:0]   a_raw;
         logic [WIDTH-1:0]   b_raw;
         logic [EW-1:0]      a_l;
         logic [EW-1:0]      b_l;
         logic [2*WIDTH-1:0] a_wide;
         logic [2*WIDTH-1:0] b_wide;
         logic [2*WIDTH-1:0] prod;

         assign a_raw = in_op0[gi*WIDTH +: WIDTH];
         assign b_raw = in_op1_scalar ? in_op1[WIDTH-1:0] : in_op1[gi*WIDTH +: WIDTH];

         // Disabled lanes are zeroed at capture, so their product is exactly
         // zero and no earlier lane data can leak to the output.
         assign a_ext[gi*EW +: EW] = in_mask[gi] ? {a_signed & a_raw[WIDTH-1], a_raw} : '0;
         assign b_ext[gi*EW +: EW] = in_mask[gi] ? {b_signed & b_raw[WIDTH-1], b_raw} : '0;

         assign a_l = a_q[gi*EW +: EW];
         assign b_l = b_q[gi*EW +: EW];

         // Sign-extend the (WIDTH+1)-bit operands to 2*WIDTH bits and
         // multiply modulo 2^(2*WIDTH). This yields the low 2*WIDTH bits of
         // the true product for every signedness mix, which covers both the
         // low and the high result halves.
         assign a_wide = {{(WIDTH-1){a_l[EW-1]}}, a_l};
         assign b_wide = {{(WIDTH-1){b_l[EW-1]}}, b_l};
         assign prod   = a_wide * b_wide;

         assign res_first[gi*WIDTH +: WIDTH] =
            (op_q[0] == OP_MUL_LO) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end
   endgenerate

   // Valid bits obey flush before enable. Data registers only follow enable:
   // a flushed slot may carry stale data, but its valid bit is already clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         for (int s = 0; s < STAGES; s++) begin
            op_q[s]   <= '0;
            tag_q[s]  <= '0;
            mask_q[s] <= '0;
         end
      end else begin
         if (flush) begin
            valid_q <= '0;
         end else if (enable) begin
            valid_q[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
               valid_q[s] <= valid_q[s-1];
            end
         end
         if (enable) begin
            a_q       <= a_ext;
            b_q       <= b_ext;
            op_q[0]   <= in_op;
            tag_q[0]  <= in_tag;
            mask_q[0] <= in_mask;
            for (int s = 1; s < STAGES; s++) begin
               op_q[s]   <= op_q[s-1];
               tag_q[s]  <= tag_q[s-1];
               mask_q[s] <= mask_q[s-1];
            end
         end
      end
   end

   // Result registers for stages 2..STAGES. With a single stage, the product
   // is taken straight from the stage 1 operand registers.
   generate
      if (STAGES == 1) begin : g_res_one
         assign out_result = res_first;
      end else begin : g_res_multi
         logic [LW-1:0] res_q [STAGES-1];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int s = 0; s < STAGES-1; s++) begin
                  res_q[s] <= '0;
               end
            end else if (enable) begin
               res_q[0] <= res_first;
               for (int s = 1; s < STAGES-1; s++) begin
                  res_q[s] <= res_q[s-1];
               end
            end
         end

         assign out_result = res_q[STAGES-2];
      end
   endgenerate

   assign out_valid = valid_q[STAGES-1];
   assign out_op    = op_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign out_mask  = mask_q[STAGES-1];
   assign busy      = |valid_q;

   // Simulation-time sanity checks.
   a_params_ok : assert property (@(posedge clk) (STAGES >= 1) && (WIDTH >= 2))
      else $error("int_mul_pipe tile %0d: illegal STAGES/WIDTH", TILE_ID);

   a_result_known : assert property (@(posedge clk) disable iff (reset)
      out_valid |-> !$isunknown(out_result))
      else $error("int_mul_pipe tile %0d: X in out_result while out_valid", TILE_ID);

endmodule

// File: tb/tb_int_mul_pipe.sv
// tb_int_mul_pipe
//   Randomised and directed bench for int_mul_pipe (LANES=4, WIDTH=32,
//   STAGES=3). The reference model is a queue of in-flight operations. Each
//   entry counts the enabled edges it still needs. Expected products come
//   from plain 64-bit arithmetic. A negedge process compares the DUT against
//   the model on every cycle. The directed sequences also pin literal values.
module tb_int_mul_pipe;

   localparam int LANES  = 4;
   localparam int WIDTH  = 32;
   localparam int STAGES = 3;
   localparam int TAG_W  = 8;
   localparam int LW     = LANES * WIDTH;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [1:0]       in_op = 2'd0;
   logic [LW-1:0]    in_op0 = '0;
   logic [LW-1:0]    in_op1 = '0;
   logic             in_op1_scalar = 1'b0;
   logic [LANES-1:0] in_mask = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic [1:0]       out_op;
   logic [LW-1:0]    out_result;
   logic [LANES-1:0] out_mask;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   int_mul_pipe #(
      .TILE_ID(0), .LANES(LANES), .WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_op(in_op), .in_op0(in_op0), .in_op1(in_op1),
      .in_op1_scalar(in_op1_scalar), .in_mask(in_mask), .in_tag(in_tag),
      .out_valid(out_valid), .out_op(out_op), .out_result(out_result),
      .out_mask(out_mask), .out_tag(out_tag), .busy(busy)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]       op;
      logic [TAG_W-1:0] tag;
      logic [LANES-1:0] mask;
      logic [LW-1:0]    res;
      int               left;
   } ent_t;

   ent_t             pend[$];
   logic             exp_valid = 1'b0;
   logic [1:0]       exp_op = '0;
   logic [TAG_W-1:0] exp_tag = '0;
   logic [LANES-1:0] exp_mask = '0;
   logic [LW-1:0]    exp_res = '0;

   function automatic logic [WIDTH-1:0] ref_lane(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic [63:0] pa;
      logic [63:0] pb;
      logic [63:0] p;
      pa = {32'h0, a};
      pb = {32'h0, b};
      if ((op == 2'd1 || op == 2'd3) && a[31]) pa[63:32] = 32'hFFFF_FFFF;
      if (op == 2'd1 && b[31]) pb[63:32] = 32'hFFFF_FFFF;
      p = pa * pb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [LW-1:0] ref_vec(input logic [1:0] op,
                                             input logic [LW-1:0] a,
                                             input logic [LW-1:0] b,
                                             input logic scalar,
                                             input logic [LANES-1:0] mask);
      logic [LW-1:0]    r;
      logic [WIDTH-1:0] bl;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         bl = scalar ? b[WIDTH-1:0] : b[i*WIDTH +: WIDTH];
         if (mask[i]) r[i*WIDTH +: WIDTH] = ref_lane(op, a[i*WIDTH +: WIDTH], bl);
      end
      return r;
   endfunction

   task automatic model_reset();
      pend.delete();
      exp_valid = 1'b0;
      exp_op    = '0;
      exp_tag   = '0;
      exp_mask  = '0;
      exp_res   = '0;
   endtask

   // Called at each rising edge with the inputs the DUT is sampling.
   task automatic model_step();
      ent_t e;
      if (reset) begin
         model_reset();
      end else if (flush) begin
         pend.delete();
         exp_valid = 1'b0;
      end else if (enable) begin
         foreach (pend[i]) pend[i].left--;
         if (in_valid) begin
            e.op   = in_op;
            e.tag  = in_tag;
            e.mask = in_mask;
            e.res  = ref_vec(in_op, in_op0, in_op1, in_op1_scalar, in_mask);
            e.left = STAGES - 1;
            pend.push_back(e);
         end
         exp_valid = 1'b0;
         if (pend.size() > 0 && pend[0].left == 0) begin
            e = pend.pop_front();
            exp_valid = 1'b1;
            exp_op    = e.op;
            exp_tag   = e.tag;
            exp_mask  = e.mask;
            exp_res   = e.res;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         chk("cyc_out_valid", 128'(out_valid), 128'(exp_valid));
         chk("cyc_busy", 128'(busy), 128'(exp_valid || (pend.size() > 0)));
         if (exp_valid) begin
            chk("cyc_op", 128'(out_op), 128'(exp_op));
            chk("cyc_tag", 128'(out_tag), 128'(exp_tag));
            chk("cyc_mask", 128'(out_mask), 128'(exp_mask));
            chk("cyc_result", 128'(out_result), 128'(exp_res));
            $display("out: tag=%02h op=%0d mask=%b result=%h", out_tag, out_op, out_mask, out_result);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic scalar, input logic [LANES-1:0] mask, input logic [TAG_W-1:0] tag);
      in_valid      = 1'b1;
      in_op         = op;
      in_op0        = a;
      in_op1        = b;
      in_op1_scalar = scalar;
      in_mask       = mask;
      in_tag        = tag;
   endtask

   function automatic logic [WIDTH-1:0] rand_word();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   logic [WIDTH-1:0] all_ff_exp [4];

   initial begin
      all_ff_exp[0] = 32'h0000_0000;   // MULH_SS
      all_ff_exp[1] = 32'hFFFF_FFFE;   // MULH_UU
      all_ff_exp[2] = 32'hFFFF_FFFF;   // MULH_SU
      all_ff_exp[3] = 32'h0000_0001;   // MUL_LO

      // Reset state
      tick();
      tick();
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_result", 128'(out_result), 128'd0);
      chk("reset_mask_tag_op", {out_mask, out_tag, out_op}, 128'd0);
      chk("reset_busy", 128'(busy), 128'd0);
      #1 reset = 1'b0;
      enable = 1'b1;

      // MUL_LO basic, latency 3
      issue(2'd0, {32'd0, 32'd5, 32'hFFFF_FFFF, 32'd7}, {32'd0, 32'd5, 32'd2, 32'd6}, 1'b0, 4'hF, 8'hA5);
      tick();
      in_valid = 1'b0;
      tick();
      chk("mullo_not_early", 128'(out_valid), 128'd0);
      tick();
      chk("mullo_valid", 128'(out_valid), 128'd1);
      chk("mullo_result", 128'(out_result), {32'd0, 32'd25, 32'hFFFF_FFFE, 32'd42});
      chk("mullo_tag", 128'(out_tag), 128'hA5);
      tick();

      // All-ones operands, four ops issued back to back
      for (int i = 0; i < 6; i++) begin
         if (i < 4) issue((i == 3) ? 2'd0 : 2'(i + 1), '1, '1, 1'b0, 4'hF, 8'(8'h10 + i));
         else in_valid = 1'b0;
         tick();
         if (i >= 2) begin
            chk("allff_valid", 128'(out_valid), 128'd1);
            chk("allff_result", 128'(out_result), {4{all_ff_exp[i-2]}});
         end
      end
      tick();

      // Scalar broadcast with a lane mask
      issue(2'd0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd9, 32'd9, 32'd9, 32'd3}, 1'b1, 4'b1011, 8'h33);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("scalar_result", 128'(out_result), {32'd12, 32'd0, 32'd6, 32'd3});
      chk("scalar_mask", 128'(out_mask), 128'b1011);
      tick();

      // Stall: two stalled edges push the result out by two edges, and the
      // output then holds while stalled again.
      issue(2'd2, {4{32'h8000_0000}}, {4{32'h0000_0004}}, 1'b0, 4'hF, 8'h44);
      tick();
      enable = 1'b0;
      tick();
      chk("stall_busy", 128'(busy), 128'd1);
      tick();
      chk("stall_no_out", 128'(out_valid), 128'd0);
      enable   = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("stall_not_yet", 128'(out_valid), 128'd0);
      tick();
      chk("stall_out", 128'(out_valid), 128'd1);
      chk("stall_result", 128'(out_result), {4{32'h0000_0002}});
      enable = 1'b0;
      tick();
      tick();
      chk("stall_hold_valid", 128'(out_valid), 128'd1);
      chk("stall_hold_tag", 128'(out_tag), 128'h44);
      enable = 1'b1;
      tick();

      // Flush kills tags 1..3; tag 4 goes through normally
      issue(2'd0, {4{32'd3}}, {4{32'd3}}, 1'b0, 4'hF, 8'd1);
      tick();
      in_tag = 8'd2;
      tick();
      in_tag = 8'd3;
      flush  = 1'b1;
      tick();
      chk("flush_busy", 128'(busy), 128'd0);
      chk("flush_out_valid", 128'(out_valid), 128'd0);
      flush  = 1'b0;
      in_tag = 8'd4;
      tick();
      in_valid = 1'b0;
      tick();
      chk("flush_quiet", 128'(out_valid), 128'd0);
      tick();
      chk("flush_tag4", {out_valid, out_tag}, {1'b1, 8'd4});
      tick();

      // Asynchronous reset with two operations in flight
      issue(2'd1, {4{32'h1234_5678}}, {4{32'h8765_4321}}, 1'b0, 4'hF, 8'h55);
      tick();
      in_tag = 8'h56;
      tick();
      in_valid = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("arst_out_valid", 128'(out_valid), 128'd0);
      chk("arst_result", 128'(out_result), 128'd0);
      chk("arst_mask_tag_op", {out_mask, out_tag, out_op}, 128'd0);
      chk("arst_busy", 128'(busy), 128'd0);
      tick();
      tick();
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("arst_no_ghost", 128'(out_valid), 128'd0);
      end

      // Randomised traffic: stalls, flushes (with and without enable), scalar
      for (int n = 0; n < 2000; n++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         enable        = ($urandom_range(0, 7) != 0);
         flush         = ($urandom_range(0, 39) == 0);
         in_op         = 2'($urandom_range(0, 3));
         in_op1_scalar = ($urandom_range(0, 3) == 0);
         in_mask       = 4'($urandom);
         in_tag        = 8'($urandom);
         for (int l = 0; l < LANES; l++) begin
            in_op0[l*WIDTH +: WIDTH] = rand_word();
            in_op1[l*WIDTH +: WIDTH] = rand_word();
         end
         tick();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      enable   = 1'b1;
      for (int i = 0; i < STAGES + 2; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
